cr_kme_fifo_v2: RTL

Parametrised synchronous FIFO for the KME datapath, the next generation of the KME FIFO wrapper. It owns its storage and pointers, and generates an input-side stall with threshold hysteresis. It also provides an optional stall override, a synchronous clear, an occupancy output, and single-cycle overflow/underflow pulses. It sits between KME pipeline stages wherever a producer needs back-pressure earlier than "full".

---
 rtl/cr_kme_fifo_v2_pkg.sv | 17 +
 rtl/cr_kme_fifo_v2_if.sv | 31 +++
 rtl/cr_kme_fifo_v2_ram.sv | 26 ++
 rtl/cr_kme_fifo_v2.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cr_kme_fifo_v2_pkg.sv
// rtl/cr_kme_fifo_v2_pkg.sv - shared types and elaboration helpers for the KME FIFO
package cr_kme_fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int depth, input int stall_at, input int resume_at);
        return (depth >= 2) && (stall_at >= 0) && (stall_at < resume_at) && (resume_at <= depth);
    endfunction

endpackage

// File: rtl/cr_kme_fifo_v2_if.sv
// rtl/cr_kme_fifo_v2_if.sv - producer/consumer handshake bundle of the KME FIFO
interface cr_kme_fifo_v2_if #(
    parameter int DATA_SIZE = 71
) ();

    logic [DATA_SIZE-1:0] fifo_in;
    logic                 fifo_in_valid;
    logic                 fifo_in_stall;
    logic [DATA_SIZE-1:0] fifo_out;
    logic                 fifo_out_valid;
    logic                 fifo_out_ack;

    modport master (
        output fifo_in,
        output fifo_in_valid,
        input  fifo_in_stall,
        input  fifo_out,
        input  fifo_out_valid,
        output fifo_out_ack
    );

    modport slave (
        input  fifo_in,
        input  fifo_in_valid,
        output fifo_in_stall,
        output fifo_out,
        output fifo_out_valid,
        input  fifo_out_ack
    );

endinterface

// File: rtl/cr_kme_fifo_v2_ram.sv
// rtl/cr_kme_fifo_v2_ram.sv - FIFO storage array, one write port and one async read port
module cr_kme_fifo_ram #(
    parameter int DATA_SIZE  = 71,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [DATA_SIZE-1:0] rd_data_o
);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cr_kme_fifo_v2.sv
// rtl/cr_kme_fifo_v2.sv - KME FIFO with stall hysteresis; CR_KME_FIFO_OUT_REG_EN adds a head flop stage
module cr_kme_fifo_v2
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_SIZE   = 71,
    parameter int FIFO_DEPTH  = 4,
    parameter int STALL_AT    = 1,
    parameter int RESUME_AT   = 2,
    parameter bit OVERRIDE_EN = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    cr_kme_fifo_v2_if.slave                     fifo_if,
    input  logic                                fifo_in_stall_override_i,
    input  logic                                fifo_clear_i,
    output logic [count_width(FIFO_DEPTH)-1:0]  fifo_used_o,
    output logic                                fifo_overflow_o,
    output logic                                fifo_underflow_o
);

    localparam int CW = count_width(FIFO_DEPTH);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    if (!params_legal(FIFO_DEPTH, STALL_AT, RESUME_AT)) begin : g_bad_params
        $error("cr_kme_fifo_v2: illegal FIFO_DEPTH/STALL_AT/RESUME_AT combination");
    end

    // Explicit wrap so non-power-of-2 depths never address past the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    ptr_t                 wr_ptr_q, wr_ptr_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    cnt_t                 used_q, used_d;
    cnt_t                 free_next;
    stall_state_e         state_q, state_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 out_valid;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 ram_rd_en;
    logic [DATA_SIZE-1:0] ram_rd_data;

    cr_kme_fifo_ram #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_fire && !fifo_clear_i),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_if.fifo_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

`ifdef CR_KME_FIFO_OUT_REG_EN
    logic                 head_valid_q, head_valid_d;
    logic [DATA_SIZE-1:0] head_q, head_d;
    cnt_t                 ram_used;

    // The head flop is one of the FIFO_DEPTH entries; storage holds the rest.
    assign ram_used  = used_q - cnt_t'(head_valid_q);
    assign out_valid = head_valid_q;
    assign ram_rd_en = (ram_used != '0) && (!head_valid_q || rd_fire);

    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (ram_rd_en) begin
            head_valid_d = 1'b1;
            head_d       = ram_rd_data;
        end else if (rd_fire) begin
            head_valid_d = 1'b0;
        end
        if (fifo_clear_i) begin
            head_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    assign fifo_if.fifo_out = head_q;
`else
    assign out_valid        = (used_q != '0);
    assign ram_rd_en        = rd_fire;
    assign fifo_if.fifo_out = out_valid ? ram_rd_data : '0;
`endif

    assign rd_fire = out_valid && fifo_if.fifo_out_ack;
    assign wr_fire = fifo_if.fifo_in_valid && ((used_q != cnt_t'(FIFO_DEPTH)) || rd_fire);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        used_d      = used_q;
        overflow_d  = fifo_if.fifo_in_valid && !wr_fire;
        underflow_d = fifo_if.fifo_out_ack && !out_valid;
        if (wr_fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (ram_rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (wr_fire && !rd_fire) begin
            used_d = used_q + cnt_t'(1);
        end else if (!wr_fire && rd_fire) begin
            used_d = used_q - cnt_t'(1);
        end
        if (fifo_clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            used_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // Hysteresis looks at the free slots that will exist after this edge.
    always_comb begin
        state_d   = state_q;
        free_next = cnt_t'(FIFO_DEPTH) - used_d;
        case (state_q)
            RUN:     if (free_next <= cnt_t'(STALL_AT))  state_d = STALL;
            STALL:   if (free_next >= cnt_t'(RESUME_AT)) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (fifo_clear_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            state_q     <= RUN;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_if.fifo_out_valid = out_valid;
    assign fifo_if.fifo_in_stall  = (state_q == STALL) && !(OVERRIDE_EN && fifo_in_stall_override_i);
    assign fifo_used_o            = used_q;
    assign fifo_overflow_o        = overflow_q;
    assign fifo_underflow_o       = underflow_q;

endmodule
